// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants, types and round-robin pick function
// Purpose: common definitions for the shared-adder round-robin arbiter.
//   DATA_W  : operand width of the shared adder
//   MAX_REQ : largest supported requester count
//   rr_pick : round-robin search returning {found, idx}
package adder_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid, searching ptr, ptr+1, ... with wrap at nreq.
  // Bits at or above nreq are never examined.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 nreq);
    pick_t r;
    int    j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!r.found && valid[j[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational 32-bit adder shared by the arbiter
// Purpose: out = a + b modulo 2^32.
// Ports:
//   a, b : operands
//   out  : truncated sum
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  assign out = a + b;

endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin picker
// Purpose: choose the first valid requester at or after ptr_i, with wrap.
// Ports:
//   valid_i : per-requester request valid
//   ptr_i   : round-robin start index
//   grant_o : one-hot grant (zero when nothing is valid)
//   idx_o   : index of the granted requester
//   found_o : a grant exists
module rr_grant
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            found_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(valid_i), IDX_W'(ptr_i), NREQ);
    found_o = pick.found;
    idx_o   = IDW'(pick.idx);
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = pick.found && (pick.idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one adder among NREQ requesters
// Purpose: grant one operand pair per cycle, add it, register the result with its ID.
// Optional feature macro: ADDER_RR_ARBITER_OVF_EN adds out_ovf (signed overflow flag).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b         : packed operands, requester i at [i*W +: W]
//   out_valid/out_ready  : result handshake
//   out_id               : owning requester
//   out_sum, out_carry   : a+b modulo 2^W and its unsigned carry-out
//   out_ovf              : signed overflow (only with ADDER_RR_ARBITER_OVF_EN)
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DATA_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDW-1:0]  out_id,
  output logic [W-1:0]    out_sum,
`ifdef ADDER_RR_ARBITER_OVF_EN
  output logic            out_ovf,
`endif
  output logic            out_carry
);

  slot_state_e     state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            found;
  logic            can_accept;
  logic            transfer;
  logic [W-1:0]    a_sel, b_sel, sum;
  logic            carry;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_grant (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .found_o (found)
  );

  assign can_accept = (state_q == SLOT_EMPTY) || out_ready;
  assign req_ready  = grant & {NREQ{can_accept}};
  assign transfer   = found && can_accept;

  assign a_sel = req_a[gidx*W +: W];
  assign b_sel = req_b[gidx*W +: W];

  adder u_adder (
    .a   (a_sel),
    .b   (b_sel),
    .out (sum)
  );

  // The adder only returns W bits; recover the carry from the operand MSBs
  // and the sum MSB (carry into the MSB is sum[W-1] ^ a[W-1] ^ b[W-1]).
  assign carry = (a_sel[W-1] & b_sel[W-1]) |
                 ((a_sel[W-1] ^ b_sel[W-1]) & ~sum[W-1]);

  assign rr_ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (transfer) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !transfer) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

`ifdef ADDER_RR_ARBITER_OVF_EN
  logic ovf_q;
  logic ovf;
  assign ovf     = (a_sel[W-1] == b_sel[W-1]) && (sum[W-1] != a_sel[W-1]);
  assign out_ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SLOT_EMPTY;
      rr_ptr_q <= '0;
      id_q     <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
`ifdef ADDER_RR_ARBITER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (transfer) begin
        rr_ptr_q <= rr_ptr_d;
        id_q     <= gidx;
        sum_q    <= sum;
        carry_q  <= carry;
`ifdef ADDER_RR_ARBITER_OVF_EN
        ovf_q    <= ovf;
`endif
      end
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_id    = id_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed self-checking bench for adder_rr_arbiter
module tb_adder_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic            out_valid;
  logic            out_ready;
  logic [IDW-1:0]  out_id;
  logic [W-1:0]    out_sum;
  logic            out_carry;
`ifdef ADDER_RR_ARBITER_OVF_EN
  logic            out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_sum   (out_sum),
`ifdef ADDER_RR_ARBITER_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    int g;
    logic [31:0] held;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b0;

    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_out_sum",   out_sum,        32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;

    // single requester
    set_req(0, 32'h1, 32'h2);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0001);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_id",    32'(out_id),    32'd0);
    chk("single_sum",   out_sum,        32'h3);
    chk("single_carry", 32'(out_carry), 32'd0);
    req_valid = 4'b0000;

    // wrap and carry, via requester 3 (rr_ptr=1 searches 1,2,3)
    set_req(3, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'b1000);
    step();
    chk("wrap1_id",    32'(out_id),    32'd3);
    chk("wrap1_sum",   out_sum,        32'h0);
    chk("wrap1_carry", 32'(out_carry), 32'd1);
`ifdef ADDER_RR_ARBITER_OVF_EN
    chk("wrap1_ovf",   32'(out_ovf),   32'd0);
`endif
    set_req(3, 32'h8000_0000, 32'h8000_0000);
    step();
    chk("wrap2_sum",   out_sum,        32'h0);
    chk("wrap2_carry", 32'(out_carry), 32'd1);
`ifdef ADDER_RR_ARBITER_OVF_EN
    chk("wrap2_ovf",   32'(out_ovf),   32'd1);
`endif
    set_req(3, 32'h7FFF_FFFF, 32'h1);
    step();
    chk("wrap3_sum",   out_sum,        32'h8000_0000);
    chk("wrap3_carry", 32'(out_carry), 32'd0);
`ifdef ADDER_RR_ARBITER_OVF_EN
    chk("wrap3_ovf",   32'(out_ovf),   32'd1);
`endif
    req_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // fairness from rr_ptr=0
    set_req(0, 32'h100, 32'h0);
    set_req(1, 32'h200, 32'h1);
    set_req(2, 32'h300, 32'h2);
    set_req(3, 32'h400, 32'h3);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      #1;
      chk($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(1 << g));
      step();
      chk($sformatf("fair_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("fair_id_%0d", k),    32'(out_id),    32'(g));
      chk($sformatf("fair_sum_%0d", k),   out_sum,        32'((g + 1) * 256 + g));
    end

    // backpressure: result from requester 1 (0x201) held, rr_ptr stays 2
    out_ready = 1'b0;
    held = 32'h201;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'd0);
      step();
      chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_id_%0d", k),    32'(out_id),    32'd1);
      chk($sformatf("bp_sum_%0d", k),   out_sum,        held);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    step();
    chk("bp_replace_valid", 32'(out_valid), 32'd1);
    chk("bp_replace_id",    32'(out_id),    32'd2);
    chk("bp_replace_sum",   out_sum,        32'h302);

    // bring rr_ptr to 2 with requester 1, then sparse 1/3
    req_valid = 4'b0010;
    #1;
    chk("sp_pre_ready", 32'(req_ready), 32'b0010);
    step();
    chk("sp_pre_id", 32'(out_id), 32'd1);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 3 : 1;
      #1;
      chk($sformatf("sp_ready_%0d", k), 32'(req_ready), 32'(1 << g));
      step();
      chk($sformatf("sp_id_%0d", k),    32'(out_id),    32'(g));
      chk($sformatf("sp_valid_%0d", k), 32'(out_valid), 32'd1);
    end
    req_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("drop_ready_%0d", k), 32'(req_ready), 32'b0010);
      step();
      chk($sformatf("drop_id_%0d", k),    32'(out_id),    32'd1);
      chk($sformatf("drop_valid_%0d", k), 32'(out_valid), 32'd1);
    end

    // asynchronous reset while a result is held
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_id",    32'(out_id),    32'd0);
    chk("arst_sum",   out_sum,        32'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_id",    32'(out_id),    32'd0);
    chk("post_rst_sum",   out_sum,        32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
